// File: rtl/bit_speck128_128_hierarchy_carry_sharing.sv
// Bit-serial Speck128/128 encryption core, 3-share threshold implementation.
// Every word (x, y, l, k) is held as three Boolean shares in 64-bit rotating
// registers. One bit of each word is produced per cycle, LSB first. Each new
// bit enters at the MSB, so after 64 cycles every word is back in its natural
// alignment.
//
// Operating modes, decoded from we / Start / round counter:
//   mode       | meaning
//   MODE_IDLE  | Start=0, nothing moves
//   MODE_LOAD  | we=1, shift plaintext and key bits in, clear counters
//   MODE_RUN   | Start=1, rounds < 32, one bit of one round per cycle
//   MODE_DONE  | Start=1, rounds = 32, x/y rotate right to stream the result
//
// Reads needing bits that the rotation has already shifted out are served by
// small side registers:
//   - ROR8 needs old bits 0..7 at bit positions 56..63. An 8-bit shadow
//     captures them during bits 0..7.
//   - ROL3 needs old bit j-3. A 3-bit delay line supplies it for j >= 3.
//     For j < 3 the old bit 61+j is still at position 61.
module bit_speck128_128_hierarchy_carry_sharing (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_ina,
    input  logic       data_inb,
    input  logic       data_inc,
    input  logic       k_data_ina,
    input  logic       k_data_inb,
    input  logic       k_data_inc,
    input  logic       carry_init_a,
    input  logic       carry_init_b,
    input  logic       carry_init_c,
    input  logic       we,
    input  logic       Start,
    output logic [1:0] cipher_out1,
    output logic [1:0] cipher_out2,
    output logic [1:0] cipher_out3,
    output logic       rndlessthan32
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_LOAD = 2'd1,
        MODE_RUN  = 2'd2,
        MODE_DONE = 2'd3
    } mode_t;

    // Share registers; index 0/1/2 = share a/b/c
    logic [63:0] x_q [3];
    logic [63:0] y_q [3];
    logic [63:0] l_q [3];
    logic [63:0] k_q [3];
    logic [7:0]  sx_q [3];
    logic [7:0]  sl_q [3];
    logic [2:0]  dy_q [3];
    logic [2:0]  dk_q [3];
    logic [2:0]  cx_q;
    logic [2:0]  cl_q;
    logic [5:0]  bit_cnt;
    logic [5:0]  rnd;

    mode_t       mode;
    logic [2:0]  din, kin, cinit;
    logic [2:0]  xr, yj, kj, lr, yrol, krol;
    logic [2:0]  cin_x, cin_l, xn, yn, ln, kn, cx_n, cl_n;
    logic [7:0]  rnd_ext;
    logic        rc;

    // Shared AND: output share i only sees input shares i+1 and i+2
    function automatic logic [2:0] and_ti(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] z;
        z[0] = (a[1] & b[1]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
        z[1] = (a[2] & b[2]) ^ (a[2] & b[0]) ^ (a[0] & b[2]);
        z[2] = (a[0] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[0]);
        return z;
    endfunction

    // Shared majority (carry-out); XOR of non-complete terms stays non-complete
    function automatic logic [2:0] maj_ti(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] c);
        return and_ti(a, b) ^ and_ti(a, c) ^ and_ti(b, c);
    endfunction

    assign rndlessthan32 = ~rnd[5];
    assign cipher_out1   = {x_q[0][0], y_q[0][0]};
    assign cipher_out2   = {x_q[1][0], y_q[1][0]};
    assign cipher_out3   = {x_q[2][0], y_q[2][0]};

    assign din     = {data_inc, data_inb, data_ina};
    assign kin     = {k_data_inc, k_data_inb, k_data_ina};
    assign cinit   = {carry_init_c, carry_init_b, carry_init_a};
    assign rnd_ext = {2'b00, rnd};

    // Mode decode; load wins over run
    always_comb begin
        mode = MODE_IDLE;
        if (we)
            mode = MODE_LOAD;
        else if (Start && rndlessthan32)
            mode = MODE_RUN;
        else if (Start)
            mode = MODE_DONE;
    end

    // One bit of the round function and key schedule, per share
    always_comb begin
        xr    = '0;
        yj    = '0;
        kj    = '0;
        lr    = '0;
        yrol  = '0;
        krol  = '0;
        cin_x = '0;
        cin_l = '0;
        rc    = (bit_cnt[5:3] == 3'd0) ? rnd_ext[bit_cnt[2:0]] : 1'b0;
        for (int s = 0; s < 3; s++) begin
            xr[s]    = (bit_cnt < 6'd56) ? x_q[s][8] : sx_q[s][0];
            lr[s]    = (bit_cnt < 6'd56) ? l_q[s][8] : sl_q[s][0];
            yj[s]    = y_q[s][0];
            kj[s]    = k_q[s][0];
            yrol[s]  = (bit_cnt < 6'd3) ? y_q[s][61] : dy_q[s][2];
            krol[s]  = (bit_cnt < 6'd3) ? k_q[s][61] : dk_q[s][2];
            cin_x[s] = (bit_cnt == 6'd0) ? cinit[s] : cx_q[s];
            cin_l[s] = (bit_cnt == 6'd0) ? cinit[s] : cl_q[s];
        end
        xn   = xr ^ yj ^ cin_x ^ kj;
        yn   = yrol ^ xn;
        ln   = lr ^ kj ^ cin_l ^ {2'b00, rc};
        kn   = krol ^ ln;
        cx_n = maj_ti(xr, yj, cin_x);
        cl_n = maj_ti(lr, kj, cin_l);
    end

    // Share registers, side registers and carries
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                x_q[s]  <= '0;
                y_q[s]  <= '0;
                l_q[s]  <= '0;
                k_q[s]  <= '0;
                sx_q[s] <= '0;
                sl_q[s] <= '0;
                dy_q[s] <= '0;
                dk_q[s] <= '0;
            end
            cx_q <= '0;
            cl_q <= '0;
        end else begin
            case (mode)
                MODE_LOAD: begin
                    for (int s = 0; s < 3; s++) begin
                        x_q[s] <= {din[s], x_q[s][63:1]};
                        y_q[s] <= {x_q[s][0], y_q[s][63:1]};
                        l_q[s] <= {kin[s], l_q[s][63:1]};
                        k_q[s] <= {l_q[s][0], k_q[s][63:1]};
                    end
                end
                MODE_RUN: begin
                    for (int s = 0; s < 3; s++) begin
                        x_q[s]  <= {xn[s], x_q[s][63:1]};
                        y_q[s]  <= {yn[s], y_q[s][63:1]};
                        l_q[s]  <= {ln[s], l_q[s][63:1]};
                        k_q[s]  <= {kn[s], k_q[s][63:1]};
                        dy_q[s] <= {dy_q[s][1:0], y_q[s][0]};
                        dk_q[s] <= {dk_q[s][1:0], k_q[s][0]};
                        if (bit_cnt < 6'd8) begin
                            sx_q[s] <= {x_q[s][0], sx_q[s][7:1]};
                            sl_q[s] <= {l_q[s][0], sl_q[s][7:1]};
                        end else if (bit_cnt >= 6'd56) begin
                            sx_q[s] <= {1'b0, sx_q[s][7:1]};
                            sl_q[s] <= {1'b0, sl_q[s][7:1]};
                        end
                    end
                    cx_q <= cx_n;
                    cl_q <= cl_n;
                end
                MODE_DONE: begin
                    for (int s = 0; s < 3; s++) begin
                        x_q[s] <= {x_q[s][0], x_q[s][63:1]};
                        y_q[s] <= {y_q[s][0], y_q[s][63:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit and round counters
    always_ff @(posedge clk) begin
        if (rst || mode == MODE_LOAD) begin
            bit_cnt <= '0;
            rnd     <= '0;
        end else if (mode == MODE_RUN) begin
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd63)
                rnd <= rnd + 6'd1;
        end
    end

endmodule

// File: tb/tb_bit_speck128_128_hierarchy_carry_sharing.sv
// Testbench for the shared bit-serial Speck128/128 core.
// It loads vectors, runs encryptions and streams the shares out.
// Expected ciphertexts come from a word-level Speck model or the published
// vector. They are queued when a run is launched and compared when the stream
// has been captured.
module tb_bit_speck128_128_hierarchy_carry_sharing;

    localparam logic [127:0] PT     = 128'h6c617669757165207469206564616d20;
    localparam logic [127:0] KEY    = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] CT_KAT = 128'ha65d9851797832657860fedf5c570d18;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_ina, data_inb, data_inc;
    logic       k_data_ina, k_data_inb, k_data_inc;
    logic       carry_init_a, carry_init_b, carry_init_c;
    logic       we, start;
    logic [1:0] cipher_out1, cipher_out2, cipher_out3;
    logic       rndlessthan32;

    int n_chk  = 0;
    int n_pass = 0;
    logic [127:0] exp_q [$];

    bit_speck128_128_hierarchy_carry_sharing dut (
        .clk          (clk),
        .rst          (rst),
        .data_ina     (data_ina),
        .data_inb     (data_inb),
        .data_inc     (data_inc),
        .k_data_ina   (k_data_ina),
        .k_data_inb   (k_data_inb),
        .k_data_inc   (k_data_inc),
        .carry_init_a (carry_init_a),
        .carry_init_b (carry_init_b),
        .carry_init_c (carry_init_c),
        .we           (we),
        .Start        (start),
        .cipher_out1  (cipher_out1),
        .cipher_out2  (cipher_out2),
        .cipher_out3  (cipher_out3),
        .rndlessthan32(rndlessthan32)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Word-level Speck128/128; cin models an unshared carry-in of 1 on every addition
    function automatic logic [127:0] speck(input logic [127:0] pt, input logic [127:0] key,
                                           input logic cin);
        logic [63:0] x, y, l, k;
        x = pt[127:64];
        y = pt[63:0];
        l = key[127:64];
        k = key[63:0];
        for (int i = 0; i < 32; i++) begin
            x = ({x[7:0], x[63:8]} + y + 64'(cin)) ^ k;
            y = {y[60:0], y[63:61]} ^ x;
            l = ({l[7:0], l[63:8]} + k + 64'(cin)) ^ 64'(i);
            k = {k[60:0], k[63:61]} ^ l;
        end
        return {x, y};
    endfunction

    function automatic logic [1:0] unshared();
        return cipher_out1 ^ cipher_out2 ^ cipher_out3;
    endfunction

    task automatic rand_carry();
        logic [31:0] r;
        r = $urandom;
        carry_init_a = r[0];
        carry_init_b = r[1];
        carry_init_c = r[0] ^ r[1];
    endtask

    task automatic load(input logic [127:0] pt, input logic [127:0] key,
                        input bit rnd_shares, input bit hold_start);
        logic [31:0] r;
        for (int i = 0; i < 128; i++) begin
            we    = 1'b1;
            start = hold_start;
            if (rnd_shares) begin
                r = $urandom;
                data_ina   = r[0];
                data_inb   = r[1];
                data_inc   = pt[i] ^ r[0] ^ r[1];
                k_data_ina = r[2];
                k_data_inb = r[3];
                k_data_inc = key[i] ^ r[2] ^ r[3];
            end else begin
                data_ina   = pt[i];
                data_inb   = 1'b0;
                data_inc   = 1'b0;
                k_data_ina = key[i];
                k_data_inb = 1'b0;
                k_data_inc = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic capture(output logic [127:0] ct);
        logic [1:0] u;
        ct = '0;
        for (int j = 0; j < 64; j++) begin
            u = unshared();
            ct[64+j] = u[1];
            ct[j]    = u[0];
            @(negedge clk);
        end
    endtask

    // Start, optionally pause for 100 cycles at active cycle pause_at, then
    // stream the result and compare it against the head of the queue
    task automatic run(input int pause_at, input int exp_lat, input bit rnd_c, input string tag);
        int w, act;
        logic [127:0] ct, exp;
        logic [1:0] u;
        w = 0;
        act = 0;
        we = 1'b0;
        start = 1'b1;
        while (rndlessthan32 && w < 5000) begin
            if (rnd_c) rand_carry();
            @(negedge clk);
            w++;
            act++;
            if (act == pause_at) begin
                start = 1'b0;
                repeat (100) @(negedge clk);
                w += 100;
                start = 1'b1;
            end
        end
        check({tag, "_latency"}, 128'(w), 128'(exp_lat));
        capture(ct);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~ct;
        check({tag, "_cipher"}, ct, exp);
        u = unshared();
        check({tag, "_wrap"}, 128'(u), 128'({exp[64], exp[0]}));
        start = 1'b0;
    endtask

    initial begin
        logic [127:0] pt2, key2;
        rst = 1'b1;
        we = 1'b0;
        start = 1'b0;
        data_ina = 0; data_inb = 0; data_inc = 0;
        k_data_ina = 0; k_data_inb = 0; k_data_inc = 0;
        carry_init_a = 0; carry_init_b = 0; carry_init_c = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out1", 128'(cipher_out1), 128'(0));
        check("rst_out2", 128'(cipher_out2), 128'(0));
        check("rst_out3", 128'(cipher_out3), 128'(0));
        check("rst_rnd", 128'(rndlessthan32), 128'(1));

        // Known answer, share a only, carry mask 1,0,1
        carry_init_a = 1; carry_init_b = 0; carry_init_c = 1;
        load(PT, KEY, 1'b0, 1'b0);
        exp_q.push_back(CT_KAT);
        run(0, 2048, 1'b0, "kat");

        // Random shares and carry masks
        load(PT, KEY, 1'b1, 1'b0);
        exp_q.push_back(speck(PT, KEY, 1'b0));
        run(0, 2048, 1'b1, "rmask");

        // Pause during round 10
        load(PT, KEY, 1'b1, 1'b0);
        exp_q.push_back(CT_KAT);
        run(10 * 64 + 5, 2148, 1'b1, "pause");

        // Reset at cycle 1000 of an encryption, then reload and rerun
        carry_init_a = 1; carry_init_b = 0; carry_init_c = 1;
        load(PT, KEY, 1'b0, 1'b0);
        we = 1'b0;
        start = 1'b1;
        repeat (1000) @(negedge clk);
        check("mid_rnd", 128'(rndlessthan32), 128'(1));
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_out1", 128'(cipher_out1), 128'(0));
        check("mrst_out2", 128'(cipher_out2), 128'(0));
        check("mrst_out3", 128'(cipher_out3), 128'(0));
        check("mrst_rnd", 128'(rndlessthan32), 128'(1));
        load(PT, KEY, 1'b1, 1'b0);
        exp_q.push_back(CT_KAT);
        run(0, 2048, 1'b0, "rerun");

        // Carry mask with XOR 1 behaves as a +1 on every addition
        carry_init_a = 1; carry_init_b = 0; carry_init_c = 0;
        load(PT, KEY, 1'b0, 1'b0);
        exp_q.push_back(speck(PT, KEY, 1'b1));
        run(0, 2048, 1'b0, "badcarry");

        // we and Start together: we wins, rounds start when we drops
        pt2  = {$urandom, $urandom, $urandom, $urandom};
        key2 = {$urandom, $urandom, $urandom, $urandom};
        carry_init_a = 0; carry_init_b = 1; carry_init_c = 1;
        load(pt2, key2, 1'b1, 1'b1);
        check("prio_held", 128'(unshared()), 128'({pt2[64], pt2[0]}));
        check("prio_rnd", 128'(rndlessthan32), 128'(1));
        exp_q.push_back(speck(pt2, key2, 1'b0));
        run(0, 2048, 1'b0, "prio");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
